mem_retire_stage: RTL
=====================

Name: mem_retire_stage

Overview:
Downstream stage of the execution units. It registers one executed instruction per handshake and performs the data-memory access that the memory unit prepared, using a variable-latency req/ack bus. It aligns and sign-extends load data, then drives the register bank write port. It stalls upstream while a memory access is outstanding and aborts a hung access with a bus-error flag after a timeout.

Parameters:
TIMEOUT_CYCLES, 255, wait cycles after request before abort; 0 disables timeout
ADDR_WIDTH, 32, width of data-memory address port

Ports:
clk  in  1  core clock, rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream holds a valid executed instruction
in_ready  out  1  stage can accept; a transfer happens when in_valid && in_ready
in_i  in  instruction_type  op selector (OP0..OP7, memoryUnit encoding)
in_is_mem  in  1  instruction belongs to memory unit
in_result  in  32  non-memory result to retire
in_we_rb  in  1  regbank write enable from execute
in_rd  in  5  destination register
in_read  in  1  load request
in_write  in  1  store request
in_addr  in  32  effective address (read or write)
in_wdata  in  32  store data, LSB-justified
in_size  in  2  01 byte, 10 half, 11 word (stores)
mem_req  out  1  bus request, held until mem_ack
mem_addr  out  ADDR_WIDTH  word-aligned address ({addr[31:2],2'b00})
mem_we  out  4  byte strobes; 0000 = read
mem_wdata  out  32  lane-replicated store data
mem_ack  in  1  single-cycle completion
mem_rdata  in  32  read data, valid with mem_ack
rb_we  out  1  regbank write strobe, one cycle
rb_addr  out  5  regbank write index
rb_data  out  32  regbank write data
bus_error  out  1  one-cycle pulse on timeout (or misalignment, see below)

Behaviour:
- Reset: state IDLE; all outputs 0 except in_ready=1; timeout counter 0; capture register cleared.
- Clock and reset: one clock (clk); reset_n is asynchronous active-low; deassertion takes effect at the next edge.
- FSM states: IDLE, ACCESS, RETIRE.
- IDLE: in_ready=1. On transfer with in_is_mem && (in_read || in_write), capture fields and go to ACCESS. mem_req rises the next cycle.
- IDLE non-memory transfer: go to RETIRE. The retirement is visible on rb_* the cycle after the transfer (latency 1).
- ACCESS: mem_req=1 and in_ready=0. Address, strobes and data stay stable until mem_ack.
  - On mem_ack: a load goes to RETIRE with aligned data; a store goes to RETIRE with rb_we forced 0.
  - mem_ack is ignored when mem_req=0.
- RETIRE: rb_we = captured we_rb && rd!=0; x0 writes are suppressed. in_ready=1, so back-to-back transfer is allowed; the next state follows the IDLE rules.
- Store strobes: byte 0001<<addr[1:0]; half 0011<<{addr[1],1'b0}; word 1111. mem_wdata is the byte replicated x4 or the half replicated x2.
- Load alignment, with byte lane addr[1:0]:
  - OP0 sign-extends the lane byte; OP1 zero-extends it.
  - OP2 sign-extends the half {addr[1]}; OP3 zero-extends it.
  - OP4 returns the full word.
- Timeout counter increments each ACCESS cycle without ack. When it equals TIMEOUT_CYCLES-1 it drops mem_req, pulses bus_error, retires with rb_we=0 and returns to IDLE. A late ack after this is ignored.
- mem_ack in the same cycle the timeout fires: the ack wins.
- Reset mid-ACCESS: mem_req drops immediately (asynchronous); the access is abandoned.

Optional Feature:
MISALIGNED_TRAP_EN.
- Defined: a half access with addr[0]=1 or a word access with addr[1:0]!=0 issues no bus request. It pulses bus_error in the cycle after capture and retires with rb_we=0.
- Undefined: low address bits are ignored for word accesses and addr[0] for half accesses; the access proceeds.

Decomposition:
- Shared package my_pkg: instruction_type (already present), an FSM state enum retire_state_t, and constants SIZE_BYTE/HALF/WORD.
- One sub-module, load_aligner: combinational rdata + addr[1:0] + op -> 32-bit result.

Test Plan:
- ADD result 0x0000_1234, rd=5, we_rb=1 -> rb_we=1, rb_addr=5, rb_data=0x0000_1234 one cycle after transfer, no mem_req.
- LB addr 0x103, mem_rdata 0x80FF_0000, ack after 3 cycles -> mem_addr 0x100, mem_we 0000, rb_data 0xFFFF_FF80. The same access with LBU -> 0x0000_0080.
- SH addr 0x202, data 0xABCD -> mem_we 1100, mem_wdata 0xABCD_ABCD, rb_we=0, in_ready low until ack.
- Write to rd=0 via LW -> no rb_we pulse; the next instruction is accepted in the RETIRE cycle.
- TIMEOUT_CYCLES=4, no ack -> mem_req falls after 4 cycles, bus_error 1-cycle pulse, no regbank write. Ack on the 4th cycle -> normal completion, no error.
- reset_n low during ACCESS -> mem_req=0 asynchronously, in_ready=1 after release. With MISALIGNED_TRAP_EN, LW addr 0x6 -> bus_error, no mem_req.

Source files
------------

// File: rtl/my_pkg.sv
// Shared types and helpers for the memory/retire stage: op encoding,
// retire FSM states, access-size codes and store lane helpers.
package my_pkg;

  typedef enum logic [2:0] {
    OP0, OP1, OP2, OP3, OP4, OP5, OP6, OP7
  } instruction_type;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RETIRE
  } retire_state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b01;
  localparam logic [1:0] SIZE_HALF = 2'b10;
  localparam logic [1:0] SIZE_WORD = 2'b11;

  // Loads carry their width in the op: byte ops, half ops, everything else word.
  function automatic logic [1:0] load_size(input instruction_type op);
    case (op)
      OP0, OP1: load_size = SIZE_BYTE;
      OP2, OP3: load_size = SIZE_HALF;
      default:  load_size = SIZE_WORD;
    endcase
  endfunction

  // Byte strobes for a store of the given size at byte lane 'lane'.
  function automatic logic [3:0] store_strobes(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SIZE_BYTE: store_strobes = 4'b0001 << lane;
      SIZE_HALF: store_strobes = 4'b0011 << {lane[1], 1'b0};
      default:   store_strobes = 4'b1111;
    endcase
  endfunction

  // Replicate LSB-justified store data across every lane it could land in.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SIZE_BYTE: store_lanes = {4{data[7:0]}};
      SIZE_HALF: store_lanes = {2{data[15:0]}};
      default:   store_lanes = data;
    endcase
  endfunction

endpackage

// File: rtl/mem_retire_stage_load_aligner.sv
// load_aligner: picks the addressed byte/half out of a bus word and
// sign- or zero-extends it according to the load op.
module load_aligner
  import my_pkg::*;
(
  input  logic [31:0]     rdata,
  input  logic [1:0]      lane,
  input  instruction_type op,
  output logic [31:0]     result
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Select the byte and half-word that the low address bits point at.
  always_comb begin
    lane_byte = rdata[7:0];
    case (lane)
      2'd0: lane_byte = rdata[7:0];
      2'd1: lane_byte = rdata[15:8];
      2'd2: lane_byte = rdata[23:16];
      2'd3: lane_byte = rdata[31:24];
      default: lane_byte = rdata[7:0];
    endcase
    lane_half = lane[1] ? rdata[31:16] : rdata[15:0];
  end

  // Extend the selected field to 32 bits; unknown ops return the raw word.
  always_comb begin
    result = rdata;
    case (op)
      OP0:     result = {{24{lane_byte[7]}}, lane_byte};
      OP1:     result = {24'h000000, lane_byte};
      OP2:     result = {{16{lane_half[15]}}, lane_half};
      OP3:     result = {16'h0000, lane_half};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_retire_stage.sv
// mem_retire_stage: registers one executed instruction per handshake,
// performs its data-memory access over a req/ack bus, aligns load data
// and drives the register bank write port.
// Optional feature macro: MISALIGNED_TRAP_EN (trap misaligned half/word
// accesses with bus_error instead of issuing them).
module mem_retire_stage
  import my_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned ADDR_WIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  instruction_type       in_i,
  input  logic                  in_is_mem,
  input  logic [31:0]           in_result,
  input  logic                  in_we_rb,
  input  logic [4:0]            in_rd,
  input  logic                  in_read,
  input  logic                  in_write,
  input  logic [31:0]           in_addr,
  input  logic [31:0]           in_wdata,
  input  logic [1:0]            in_size,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_we,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata,
  output logic                  rb_we,
  output logic [4:0]            rb_addr,
  output logic [31:0]           rb_data,
  output logic                  bus_error
);

  // Counter only has to reach TIMEOUT_CYCLES-1; a zero setting disables it.
  localparam int unsigned     CNT_W      = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  retire_state_t         state;
  retire_state_t         next_state;
  logic [CNT_W-1:0]      wait_cnt;

  logic                  cap_load;
  instruction_type       cap_op;
  logic [1:0]            cap_lane;
  logic [4:0]            cap_rd;
  logic                  cap_we_rb;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            we_q;
  logic [31:0]           wdata_q;
  logic                  ret_we;
  logic [31:0]           ret_data;
  logic                  bus_error_q;

  logic                  take;
  logic                  start_mem;
  logic                  misaligned;
  logic                  ack_hit;
  logic                  timeout_hit;
  logic [31:0]           aligned_data;

  load_aligner u_aligner (
    .rdata  (mem_rdata),
    .lane   (cap_lane),
    .op     (cap_op),
    .result (aligned_data)
  );

  // Handshake, access-start, ack and timeout qualifiers for this cycle.
  always_comb begin
    take        = in_valid && (state != ACCESS);
    start_mem   = take && in_is_mem && (in_read || in_write);
    ack_hit     = (state == ACCESS) && mem_ack;
    timeout_hit = TIMEOUT_EN && (state == ACCESS) && !mem_ack && (wait_cnt == CNT_LAST);
`ifdef MISALIGNED_TRAP_EN
    begin
      logic [1:0] access_size;
      access_size = in_read ? load_size(in_i) : in_size;
      misaligned  = ((access_size == SIZE_HALF) && in_addr[0]) ||
                    ((access_size == SIZE_WORD) && (in_addr[1:0] != 2'b00));
    end
`else
    misaligned  = 1'b0;
`endif
  end

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next state and handshake outputs; RETIRE accepts like IDLE for back-to-back flow.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    mem_req    = 1'b0;
    rb_we      = 1'b0;
    case (state)
      IDLE, RETIRE: begin
        in_ready = 1'b1;
        rb_we    = (state == RETIRE) && ret_we;
        if (take) begin
          if (start_mem) next_state = misaligned ? RETIRE : ACCESS;
          else           next_state = RETIRE;
        end else begin
          next_state = IDLE;
        end
      end
      ACCESS: begin
        mem_req = 1'b1;
        if (mem_ack)          next_state = RETIRE;
        else if (timeout_hit) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Count un-acked wait cycles of the current access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                         wait_cnt <= '0;
    else if (start_mem)                   wait_cnt <= '0;
    else if ((state == ACCESS) && !mem_ack) wait_cnt <= wait_cnt + 1'b1;
  end

  // Capture the instruction on transfer and the retirement result on ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_load  <= 1'b0;
      cap_op    <= OP0;
      cap_lane  <= 2'b00;
      cap_rd    <= 5'd0;
      cap_we_rb <= 1'b0;
      addr_q    <= '0;
      we_q      <= 4'b0000;
      wdata_q   <= 32'h0;
      ret_we    <= 1'b0;
      ret_data  <= 32'h0;
    end else if (take) begin
      cap_load  <= in_read;
      cap_op    <= in_i;
      cap_lane  <= in_addr[1:0];
      cap_rd    <= in_rd;
      cap_we_rb <= in_we_rb;
      ret_we    <= !start_mem && in_we_rb && (in_rd != 5'd0);
      ret_data  <= start_mem ? 32'h0 : in_result;
      if (start_mem) begin
        addr_q  <= ADDR_WIDTH'({in_addr[31:2], 2'b00});
        we_q    <= in_read ? 4'b0000 : store_strobes(in_size, in_addr[1:0]);
        wdata_q <= in_read ? 32'h0 : store_lanes(in_size, in_wdata);
      end
    end else if (ack_hit) begin
      ret_we   <= cap_load && cap_we_rb && (cap_rd != 5'd0);
      ret_data <= cap_load ? aligned_data : 32'h0;
    end
  end

  // One-cycle error pulse after a timeout or a trapped misaligned access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bus_error_q <= 1'b0;
    else          bus_error_q <= timeout_hit || (start_mem && misaligned);
  end

  assign mem_addr  = addr_q;
  assign mem_we    = we_q;
  assign mem_wdata = wdata_q;
  assign rb_addr   = cap_rd;
  assign rb_data   = ret_data;
  assign bus_error = bus_error_q;

endmodule
